// File: rtl/sig_compactor.sv
// Response compactor: folds din into a MISR over CYCLES accepted beats, then compares against GOLDEN.
// Optional macro SIG_SERIAL_OUT_EN adds a WIDTH-cycle MSB-first serial dump of the signature before done.
module sig_compactor #(
    parameter int               WIDTH  = 7,
    parameter int               N_IN   = 3,
    parameter logic [WIDTH-1:0] TAPS   = 7'b1100000,
    parameter logic [WIDTH-1:0] SEED   = '0,
    parameter int               CYCLES = 16,
    parameter logic [WIDTH-1:0] GOLDEN = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             en,
    input  logic [N_IN-1:0]  din,
    output logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
`ifdef SIG_SERIAL_OUT_EN
    output logic             so_data,
    output logic             so_valid,
`endif
    output logic             pass_fail
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        COMPACT,
        COMPARE,
`ifdef SIG_SERIAL_OUT_EN
        SHIFTOUT,
`endif
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d, sig_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_fail_q, pass_fail_d;
    logic             fb;

`ifdef SIG_SERIAL_OUT_EN
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             so_data_q, so_data_d;
    logic             so_valid_q, so_valid_d;
`endif

    // One MISR step: shift up with tap feedback into bit 0, then XOR the response into the low bits.
    always_comb begin
        fb       = ^(sig_q & TAPS);
        sig_step = {sig_q[WIDTH-2:0], fb} ^ WIDTH'(din);
    end

    always_comb begin
        state_d     = state_q;
        sig_d       = sig_q;
        cnt_d       = cnt_q;
        pass_fail_d = pass_fail_q;
`ifdef SIG_SERIAL_OUT_EN
        shift_d     = shift_q;
        bit_d       = bit_q;
        so_data_d   = so_data_q;
        so_valid_d  = so_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    state_d = COMPACT;
                end
            end
            COMPACT: begin
                // The final beat leaves cnt parked at CYCLES-1 so it never wraps.
                if (en) begin
                    sig_d = sig_step;
                    if (cnt_q == LAST_CNT) begin
                        state_d = COMPARE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMPARE: begin
                pass_fail_d = (sig_q == GOLDEN);
`ifdef SIG_SERIAL_OUT_EN
                shift_d    = sig_q << 1;
                bit_d      = '0;
                so_data_d  = sig_q[WIDTH-1];
                so_valid_d = 1'b1;
                state_d    = SHIFTOUT;
`else
                state_d = DONE;
`endif
            end
`ifdef SIG_SERIAL_OUT_EN
            SHIFTOUT: begin
                if (bit_q == LAST_BIT) begin
                    so_data_d  = 1'b0;
                    so_valid_d = 1'b0;
                    state_d    = DONE;
                end else begin
                    so_data_d = shift_q[WIDTH-1];
                    shift_d   = shift_q << 1;
                    bit_d     = bit_q + 1'b1;
                end
            end
`endif
            DONE: begin
                if (start) begin
                    sig_d       = SEED;
                    cnt_d       = '0;
                    pass_fail_d = 1'b0;
                    state_d     = COMPACT;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == COMPACT) || (state_d == COMPARE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            sig_q       <= SEED;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_fail_q <= 1'b0;
`ifdef SIG_SERIAL_OUT_EN
            shift_q     <= '0;
            bit_q       <= '0;
            so_data_q   <= 1'b0;
            so_valid_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_fail_q <= pass_fail_d;
`ifdef SIG_SERIAL_OUT_EN
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            so_data_q   <= so_data_d;
            so_valid_q  <= so_valid_d;
`endif
        end
    end

    assign sig       = sig_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_fail = pass_fail_q;
`ifdef SIG_SERIAL_OUT_EN
    assign so_data   = so_data_q;
    assign so_valid  = so_valid_q;
`endif

endmodule

// File: tb/tb_sig_compactor.sv
// Directed bench for sig_compactor: four instances (default, CYCLES=2, CYCLES=4, CYCLES=1)
// share clock, reset, en and din but have private start strobes.
module tb_sig_compactor;

    logic       CLK;
    logic       RST;
    logic       en;
    logic [2:0] din;
    logic       start_def, start_c2, start_c4, start_c1;

    logic [6:0] sig_def, sig_c2, sig_c4, sig_c1;
    logic       busy_def, busy_c2, busy_c4, busy_c1;
    logic       done_def, done_c2, done_c4, done_c1;
    logic       pf_def, pf_c2, pf_c4, pf_c1;
`ifdef SIG_SERIAL_OUT_EN
    logic       sod_def, sod_c2, sod_c4, sod_c1;
    logic       sov_def, sov_c2, sov_c4, sov_c1;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    sig_compactor u_def (
        .CLK(CLK), .RST(RST), .start(start_def), .en(en), .din(din),
        .sig(sig_def), .busy(busy_def), .done(done_def),
`ifdef SIG_SERIAL_OUT_EN
        .so_data(sod_def), .so_valid(sov_def),
`endif
        .pass_fail(pf_def)
    );

    sig_compactor #(.CYCLES(2), .GOLDEN(7'd2)) u_c2 (
        .CLK(CLK), .RST(RST), .start(start_c2), .en(en), .din(din),
        .sig(sig_c2), .busy(busy_c2), .done(done_c2),
`ifdef SIG_SERIAL_OUT_EN
        .so_data(sod_c2), .so_valid(sov_c2),
`endif
        .pass_fail(pf_c2)
    );

    sig_compactor #(.CYCLES(4), .GOLDEN(7'd15)) u_c4 (
        .CLK(CLK), .RST(RST), .start(start_c4), .en(en), .din(din),
        .sig(sig_c4), .busy(busy_c4), .done(done_c4),
`ifdef SIG_SERIAL_OUT_EN
        .so_data(sod_c4), .so_valid(sov_c4),
`endif
        .pass_fail(pf_c4)
    );

    sig_compactor #(.CYCLES(1), .GOLDEN(7'd5)) u_c1 (
        .CLK(CLK), .RST(RST), .start(start_c1), .en(en), .din(din),
        .sig(sig_c1), .busy(busy_c1), .done(done_c1),
`ifdef SIG_SERIAL_OUT_EN
        .so_data(sod_c1), .so_valid(sov_c1),
`endif
        .pass_fail(pf_c1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive en/din for one cycle; returns 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic e, input logic [2:0] d);
        en  = e;
        din = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [6:0] ser_exp;

        RST = 1'b1; en = 1'b0; din = '0;
        start_def = 1'b0; start_c2 = 1'b0; start_c4 = 1'b0; start_c1 = 1'b0;

        // Reset, then idle with no start
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 3'b000);
            checkOutput("rst_sig", 32'(sig_def), 32'd0);
            checkOutput("rst_busy", 32'(busy_def), 32'd0);
            checkOutput("rst_done", 32'(done_def), 32'd0);
            checkOutput("rst_pf", 32'(pf_def), 32'd0);
        end
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 3'b111);
            checkOutput("idle_sig", 32'(sig_def), 32'd0);
            checkOutput("idle_busy", 32'(busy_def), 32'd0);
            checkOutput("idle_done", 32'(done_def), 32'd0);
            checkOutput("idle_pf", 32'(pf_def), 32'd0);
        end
`ifdef SIG_SERIAL_OUT_EN
        checkOutput("idle_sov", 32'({sov_def, sov_c2, sov_c4, sov_c1}), 32'd0);
        checkOutput("idle_sod", 32'({sod_def, sod_c2, sod_c4, sod_c1}), 32'd0);
`endif

        // Zero response, default parameters
        start_def = 1'b1;
        applyStimulus(1'b0, 3'b000);
        start_def = 1'b0;
        checkOutput("zero_busy_start", 32'(busy_def), 32'd1);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 3'b000);
        checkOutput("zero_busy_cmp", 32'(busy_def), 32'd1);
        checkOutput("zero_done_early", 32'(done_def), 32'd0);
        applyStimulus(1'b0, 3'b000);
        checkOutput("zero_done", 32'(done_def), 32'd1);
        checkOutput("zero_busy_end", 32'(busy_def), 32'd0);
        checkOutput("zero_pf", 32'(pf_def), 32'd1);
        checkOutput("zero_sig", 32'(sig_def), 32'd0);

        // CYCLES=2 arithmetic: 001,000 -> 1,2 (pass)
        start_c2 = 1'b1;
        applyStimulus(1'b0, 3'b000);
        start_c2 = 1'b0;
        applyStimulus(1'b1, 3'b001);
        checkOutput("c2_sig1", 32'(sig_c2), 32'd1);
        applyStimulus(1'b1, 3'b000);
        checkOutput("c2_sig2", 32'(sig_c2), 32'd2);
        checkOutput("c2_done_early", 32'(done_c2), 32'd0);
        applyStimulus(1'b0, 3'b000);
        checkOutput("c2_done", 32'(done_c2), 32'd1);
        checkOutput("c2_pf", 32'(pf_c2), 32'd1);

        // Back-to-back restart from DONE, then 101,000 -> 5,10 (fail)
        start_c2 = 1'b1;
        applyStimulus(1'b0, 3'b000);
        start_c2 = 1'b0;
        checkOutput("c2_restart_done", 32'(done_c2), 32'd0);
        checkOutput("c2_restart_pf", 32'(pf_c2), 32'd0);
        checkOutput("c2_restart_sig", 32'(sig_c2), 32'd0);
        checkOutput("c2_restart_busy", 32'(busy_c2), 32'd1);
        applyStimulus(1'b1, 3'b101);
        checkOutput("c2b_sig1", 32'(sig_c2), 32'd5);
        applyStimulus(1'b1, 3'b000);
        checkOutput("c2b_sig2", 32'(sig_c2), 32'd10);
        applyStimulus(1'b0, 3'b000);
        checkOutput("c2b_done", 32'(done_c2), 32'd1);
        checkOutput("c2b_pf", 32'(pf_c2), 32'd0);
        checkOutput("c2b_sig_hold", 32'(sig_c2), 32'd10);

        // CYCLES=4 with en gaps (junk din on gaps) and a start pulse mid-run
        start_c4 = 1'b1;
        applyStimulus(1'b0, 3'b000);
        start_c4 = 1'b0;
        applyStimulus(1'b1, 3'b001);
        applyStimulus(1'b0, 3'b111);
        checkOutput("c4_gap_sig", 32'(sig_c4), 32'd1);
        applyStimulus(1'b1, 3'b001);
        checkOutput("c4_sig2", 32'(sig_c4), 32'd3);
        applyStimulus(1'b0, 3'b111);
        start_c4 = 1'b1;
        applyStimulus(1'b0, 3'b111);
        start_c4 = 1'b0;
        checkOutput("c4_midstart_sig", 32'(sig_c4), 32'd3);
        checkOutput("c4_midstart_busy", 32'(busy_c4), 32'd1);
        applyStimulus(1'b1, 3'b001);
        checkOutput("c4_sig3", 32'(sig_c4), 32'd7);
        applyStimulus(1'b1, 3'b001);
        checkOutput("c4_sig4", 32'(sig_c4), 32'd15);
        checkOutput("c4_done_early", 32'(done_c4), 32'd0);
        applyStimulus(1'b1, 3'b111);
        checkOutput("c4_done", 32'(done_c4), 32'd1);
        checkOutput("c4_pf", 32'(pf_c4), 32'd1);
        checkOutput("c4_sig_final", 32'(sig_c4), 32'd15);
        applyStimulus(1'b0, 3'b000);

        // Restart default from DONE, then reset after 3 of 16 beats
        start_def = 1'b1;
        applyStimulus(1'b0, 3'b000);
        start_def = 1'b0;
        checkOutput("mid_restart_done", 32'(done_def), 32'd0);
        checkOutput("mid_restart_pf", 32'(pf_def), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b111);
        checkOutput("mid_partial_sig", 32'(sig_def), 32'd21);
        RST = 1'b1;
        applyStimulus(1'b0, 3'b000);
        RST = 1'b0;
        checkOutput("mid_rst_sig", 32'(sig_def), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy_def), 32'd0);
        applyStimulus(1'b1, 3'b111);
        checkOutput("mid_rst_idle_sig", 32'(sig_def), 32'd0);
        start_def = 1'b1;
        applyStimulus(1'b0, 3'b000);
        start_def = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 3'b000);
        applyStimulus(1'b0, 3'b000);
        checkOutput("mid_rerun_done", 32'(done_def), 32'd1);
        checkOutput("mid_rerun_pf", 32'(pf_def), 32'd1);

        // Feedback exercised: 100 then 15 zeros -> 65 after 5 beats, 5 after 13, 40 final
        start_def = 1'b1;
        applyStimulus(1'b0, 3'b000);
        start_def = 1'b0;
        applyStimulus(1'b1, 3'b100);
        checkOutput("tap_sig1", 32'(sig_def), 32'd4);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b1, 3'b000);
            if (i == 4)  checkOutput("tap_sig5", 32'(sig_def), 32'd65);
            if (i == 12) checkOutput("tap_sig13", 32'(sig_def), 32'd5);
        end
        checkOutput("tap_sig16", 32'(sig_def), 32'd40);
        applyStimulus(1'b0, 3'b000);
        checkOutput("tap_done", 32'(done_def), 32'd1);
        checkOutput("tap_pf", 32'(pf_def), 32'd0);

        // CYCLES=1, din=101
        start_c1 = 1'b1;
        applyStimulus(1'b0, 3'b000);
        start_c1 = 1'b0;
        applyStimulus(1'b1, 3'b101);
        checkOutput("c1_sig", 32'(sig_c1), 32'd5);
        checkOutput("c1_busy", 32'(busy_c1), 32'd1);
        checkOutput("c1_done_early", 32'(done_c1), 32'd0);
`ifdef SIG_SERIAL_OUT_EN
        ser_exp = 7'b0000101;
        applyStimulus(1'b0, 3'b000);
        for (int k = 0; k < 7; k++) begin
            checkOutput("c1_so_valid", 32'(sov_c1), 32'd1);
            checkOutput("c1_so_data", 32'(sod_c1), 32'(ser_exp[6-k]));
            checkOutput("c1_so_done", 32'(done_c1), 32'd0);
            applyStimulus(1'b0, 3'b000);
        end
        checkOutput("c1_so_valid_end", 32'(sov_c1), 32'd0);
        checkOutput("c1_so_data_end", 32'(sod_c1), 32'd0);
`else
        ser_exp = 7'd5;
        applyStimulus(1'b0, 3'b000);
`endif
        checkOutput("c1_done", 32'(done_c1), 32'd1);
        checkOutput("c1_pf", 32'(pf_c1), 32'd1);
        checkOutput("c1_sig_hold", 32'(sig_c1), 32'(ser_exp));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
